// File: rtl/minmax_stream.sv
// minmax_stream: pipelined arg-min/arg-max frame reducer; in_* beat stream (vld/rdy/last/mode/msk/dat) -> out_* result (vld/rdy/found/idx/val)
module minmax_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int PORT       = 4,
  parameter int IDX_WIDTH  = 16,
  parameter int SIGNED     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic                       in_last,
  input  logic                       in_mode,
  input  logic [PORT-1:0]            in_msk,
  input  logic [DATA_WIDTH*PORT-1:0] in_dat,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic                       out_found,
  output logic [IDX_WIDTH-1:0]       out_idx,
  output logic [DATA_WIDTH-1:0]      out_val
);
  localparam int LW = $clog2(PORT);
  localparam int NN = 2*PORT-1;
  typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;
  state_t state_q, state_d;
  function automatic logic better(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b, input logic mx);
    logic lt, gt;
    lt = (SIGNED != 0) ? ($signed(a) < $signed(b)) : (a < b);
    gt = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
    return mx ? gt : lt;
  endfunction
  logic                  acc, first, eff_mode;
  logic                  mode_q, mode_d;
  logic [IDX_WIDTH-1:0]  beat_q, beat_d, cur_beat;
  logic                  s1_vld_q, s1_first_q, s1_any_q;
  logic [DATA_WIDTH-1:0] s1_val_q;
  logic [LW-1:0]         s1_lane_q;
  logic [IDX_WIDTH-1:0]  s1_beat_q;
  logic                  best_any_q, best_any_d;
  logic [DATA_WIDTH-1:0] best_val_q, best_val_d;
  logic [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;
  logic [IDX_WIDTH-1:0]  cand_idx;
  logic                  replace, clear;
  logic [DATA_WIDTH-1:0] t_val  [NN];
  logic [LW-1:0]         t_lane [NN];
  logic                  t_any  [NN];
  assign in_rdy   = rst_n && (state_q == IDLE || state_q == ACC);
  assign acc      = in_vld && in_rdy;
  assign first    = state_q == IDLE;
  assign eff_mode = first ? in_mode : mode_q;
  assign cur_beat = first ? '0 : beat_q;
  for (genvar j = 0; j < PORT; j++) begin : g_leaf
    assign t_val[PORT-1+j]  = in_dat[DATA_WIDTH*j +: DATA_WIDTH];
    assign t_lane[PORT-1+j] = LW'(j);
    assign t_any[PORT-1+j]  = in_msk[j];
  end
  for (genvar n = 0; n < PORT-1; n++) begin : g_node
    logic take_r;
    assign take_r    = t_any[2*n+2] && (!t_any[2*n+1] || better(t_val[2*n+2], t_val[2*n+1], eff_mode));
    assign t_val[n]  = take_r ? t_val[2*n+2]  : t_val[2*n+1];
    assign t_lane[n] = take_r ? t_lane[2*n+2] : t_lane[2*n+1];
    assign t_any[n]  = t_any[2*n+1] || t_any[2*n+2];
  end
  always_comb begin
    state_d = (acc && in_last) ? DRAIN :
              acc ? ACC :
              (state_q == DRAIN) ? HOLD :
              (state_q == HOLD && out_rdy) ? IDLE : state_q;
    mode_d     = (acc && first) ? in_mode : mode_q;
    beat_d     = acc ? cur_beat + IDX_WIDTH'(1) : beat_q;
    cand_idx   = IDX_WIDTH'({s1_beat_q, s1_lane_q});
    clear      = s1_vld_q && s1_first_q;
    replace    = s1_vld_q && s1_any_q && (s1_first_q || !best_any_q || better(s1_val_q, best_val_q, mode_q));
    best_any_d = replace || (best_any_q && !clear);
    best_val_d = replace ? s1_val_q : clear ? '0 : best_val_q;
    best_idx_d = replace ? cand_idx : clear ? '0 : best_idx_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      beat_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_any_q   <= 1'b0;
      s1_val_q   <= '0;
      s1_lane_q  <= '0;
      s1_beat_q  <= '0;
      best_any_q <= 1'b0;
      best_val_q <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      beat_q     <= beat_d;
      s1_vld_q   <= acc;
      if (acc) begin
        s1_first_q <= first;
        s1_any_q   <= t_any[0];
        s1_val_q   <= t_val[0];
        s1_lane_q  <= t_lane[0];
        s1_beat_q  <= cur_beat;
      end
      best_any_q <= best_any_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
    end
  end
  assign out_vld   = state_q == HOLD;
  assign out_found = best_any_q;
  assign out_idx   = best_idx_q;
  assign out_val   = best_val_q;
endmodule
